// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg: shared FSM encoding, byte width and grant-index helper for the UART TX arbiter
package uart_tx_arbiter_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_PULSE = 3'd2,
        S_WAITB = 3'd3,
        S_WAITD = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    // Index of the set bit in a one-hot vector of up to 8 requesters
    function automatic logic [2:0] oh_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// uart_tx_arbiter_rr_pick: combinational round-robin picker; lowest valid index at or above ptr wins
module uart_tx_arbiter_rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] valid,
    input  logic [2:0]   ptr,
    output logic [N-1:0] onehot,
    output logic         any
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] j;

    // Scan from the farthest candidate back toward ptr so the nearest valid one is written last and wins
    always_comb begin
        onehot = '0;
        j = '0;
        for (int i = N - 1; i >= 0; i--) begin
            j = IW'((int'(ptr) + i) % N);
            if (valid[j]) begin
                onehot = '0;
                onehot[j] = 1'b1;
            end
        end
    end

    assign any = |valid;

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART byte transmitter; watchdog via UART_TX_ARB_WDOG_EN
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int GAP_CYCLES  = 0,
    parameter int WDOG_CYCLES = 8
) (
    input  logic                         I_clk,
    input  logic                         I_uart_rstn,
    input  logic [N_REQ-1:0]             I_req_valid,
    input  logic [UART_BYTE_W*N_REQ-1:0] I_req_data,
    input  logic [N_REQ-1:0]             I_req_last,
    output logic [N_REQ-1:0]             O_req_ready,
    output logic [N_REQ-1:0]             O_grant,
    output logic                         O_uart_wreq,
    output logic [UART_BYTE_W-1:0]       O_uart_wdata,
    input  logic                         I_uart_wbusy,
    output logic                         O_tx_err
);

    state_t                 state;
    logic [2:0]             rr_ptr;
    logic [2:0]             g_idx;
    logic                   last_r;
    logic                   any;
    logic                   sel_last;
    logic                   gap_done;
    logic [N_REQ-1:0]       pick;
    logic [UART_BYTE_W-1:0] sel_data;
    logic [15:0]            gap_cnt;
`ifdef UART_TX_ARB_WDOG_EN
    logic [15:0]            wd_cnt;
`endif

    uart_tx_arbiter_rr_pick #(.N(N_REQ)) u_pick (
        .valid  (I_req_valid),
        .ptr    (rr_ptr),
        .onehot (pick),
        .any    (any)
    );

    assign O_req_ready = (state == S_FETCH) ? (I_req_valid & O_grant) : '0;
    assign g_idx       = oh_idx(8'(O_grant));
    assign gap_done    = (17'(gap_cnt) + 17'd1) >= 17'(GAP_CYCLES);

    // Route the owner's byte and last flag toward the holding register
    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (O_grant[k]) begin
                sel_data = I_req_data[k*UART_BYTE_W +: UART_BYTE_W];
                sel_last = I_req_last[k];
            end
        end
    end

    // Arbitration and transmitter handshake FSM; grant, pulse and byte are all registered
    always_ff @(posedge I_clk or negedge I_uart_rstn) begin
        if (!I_uart_rstn) begin
            state        <= S_IDLE;
            O_grant      <= '0;
            O_uart_wreq  <= 1'b0;
            O_uart_wdata <= '0;
            last_r       <= 1'b0;
            rr_ptr       <= '0;
            gap_cnt      <= '0;
`ifdef UART_TX_ARB_WDOG_EN
            wd_cnt       <= '0;
            O_tx_err     <= 1'b0;
`endif
        end else begin
            O_uart_wreq <= 1'b0;
`ifdef UART_TX_ARB_WDOG_EN
            O_tx_err    <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (any) begin
                        O_grant <= pick;
                        state   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (|O_req_ready) begin
                        O_uart_wdata <= sel_data;
                        last_r       <= sel_last;
                        O_uart_wreq  <= 1'b1;
                        state        <= S_PULSE;
                    end
                end
                S_PULSE: begin
`ifdef UART_TX_ARB_WDOG_EN
                    wd_cnt <= '0;
`endif
                    state <= S_WAITB;
                end
                S_WAITB: begin
                    if (I_uart_wbusy) begin
                        state <= S_WAITD;
`ifdef UART_TX_ARB_WDOG_EN
                    end else if (wd_cnt == 16'(WDOG_CYCLES - 1)) begin
                        O_tx_err <= 1'b1;
                        gap_cnt  <= '0;
                        state    <= S_GAP;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
`endif
                    end
                end
                S_WAITD: begin
                    if (!I_uart_wbusy) begin
                        gap_cnt <= '0;
                        state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (!gap_done) begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end else if (last_r) begin
                        rr_ptr  <= (g_idx == 3'(N_REQ - 1)) ? 3'd0 : g_idx + 3'd1;
                        O_grant <= '0;
                        state   <= S_IDLE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef UART_TX_ARB_WDOG_EN
    // No watchdog: error output is constant low (expression folds to 0 for any legal WDOG_CYCLES)
    assign O_tx_err = (WDOG_CYCLES < 0);
`endif

endmodule
